// File: rtl/ts_bus_pkg.sv
// rtl/ts_bus_pkg.sv - shared bus widths and responder state encoding
package ts_bus_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_DRIVE = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_WR_HOLD  = 3'd4
    } resp_state_t;

endpackage

// File: rtl/ts_mem_array.sv
// rtl/ts_mem_array.sv - single-port doubleword store, synchronous write, asynchronous read
module ts_mem_array
    import ts_bus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     read_data
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Commit one doubleword per enabled edge; contents are deliberately left uninitialised.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[index] <= write_data;
        end
    end

    assign read_data = mem[index];

endmodule

// File: rtl/ts_memory_responder.sv
// rtl/ts_memory_responder.sv - wait-stated memory responder on a shared tri-state bus; TS_MEM_FAULT_EN adds the fault port
module ts_memory_responder
    import ts_bus_pkg::*;
#(
    parameter int                DEPTH_LOG2  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] address,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              ready
`ifdef TS_MEM_FAULT_EN
    ,
    output logic              fault
`endif
);

    localparam int TAG_LSB = DEPTH_LOG2 + 3;

    resp_state_t           state;
    logic [3:0]            count;
    logic [DEPTH_LOG2-1:0] index_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] index;
    logic                  last_wait;
    logic                  mem_we;
    logic                  bad_req;
    logic                  fault_hold;

    assign hit       = (address >> TAG_LSB) == (BASE_ADDR >> TAG_LSB);
    assign index     = address[TAG_LSB-1:3];
    // A count of 1 (or 0 when WAIT_STATES is 0) means this edge finishes the wait.
    assign last_wait = (count <= 4'd1);

`ifdef TS_MEM_FAULT_EN
    assign bad_req = hit && ((address[2:0] != 3'b000) || (mem_read && mem_write));
`else
    logic unused_low_addr;
    assign unused_low_addr = ^address[2:0];
    assign bad_req         = 1'b0;
`endif

    // Reset gates the commit so an interrupted write never lands.
    assign mem_we = (state == ST_WR_WAIT) && mem_write && last_wait && !reset;

    // Release is combinational on mem_read and reset so the bus frees in the same cycle.
    assign data = (state == ST_RD_DRIVE && mem_read && !reset) ? rdata : {DATA_W{1'bz}};

    ts_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock      (clock),
        .write_en   (mem_we),
        .index      (index_q),
        .write_data (wdata_q),
        .read_data  (rdata)
    );

    // Request sequencing: accept in IDLE, count wait states, pulse ready, hold until the request drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= 4'd0;
            ready      <= 1'b0;
            index_q    <= '0;
            wdata_q    <= '0;
            fault_hold <= 1'b0;
`ifdef TS_MEM_FAULT_EN
            fault      <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
`ifdef TS_MEM_FAULT_EN
            fault <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (fault_hold) begin
                        if (!mem_read && !mem_write) begin
                            fault_hold <= 1'b0;
                        end
                    end else if (bad_req) begin
                        fault_hold <= 1'b1;
`ifdef TS_MEM_FAULT_EN
                        fault      <= 1'b1;
`endif
                    end else if (hit && mem_write) begin
                        index_q <= index;
                        wdata_q <= data;
                        count   <= 4'(WAIT_STATES);
                        state   <= ST_WR_WAIT;
                    end else if (hit && mem_read) begin
                        index_q <= index;
                        count   <= 4'(WAIT_STATES);
                        state   <= (WAIT_STATES == 0) ? ST_RD_DRIVE : ST_RD_WAIT;
                        ready   <= (WAIT_STATES == 0);
                    end
                end
                ST_RD_WAIT: begin
                    if (!mem_read) begin
                        state <= ST_IDLE;
                    end else if (last_wait) begin
                        count <= 4'd0;
                        ready <= 1'b1;
                        state <= ST_RD_DRIVE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_RD_DRIVE: begin
                    if (!mem_read) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WR_WAIT: begin
                    if (!mem_write) begin
                        state <= ST_IDLE;
                    end else if (last_wait) begin
                        count <= 4'd0;
                        ready <= 1'b1;
                        state <= ST_WR_HOLD;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_WR_HOLD: begin
                    if (!mem_write) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_memory_responder.sv
// tb/tb_ts_memory_responder.sv - self-checking bench for ts_memory_responder across four parameter sets
module tb_ts_memory_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic        tb_en;
    logic [63:0] tb_val;

    wire [63:0] bus_a, bus_b, bus_c, bus_d;
    logic       ready_a, ready_b, ready_c, ready_d;

    assign bus_a = tb_en ? tb_val : 64'bz;
    assign bus_b = tb_en ? tb_val : 64'bz;
    assign bus_c = tb_en ? tb_val : 64'bz;
    assign bus_d = tb_en ? tb_val : 64'bz;

    wire z_a = (bus_a === 64'bz);
    wire z_b = (bus_b === 64'bz);
    wire z_c = (bus_c === 64'bz);
    wire z_d = (bus_d === 64'bz);

`ifdef TS_MEM_FAULT_EN
    logic fault_a, fault_b, fault_c, fault_d;
`endif

    int n_cmp;
    int n_fail;

    logic [63:0] model [256];
    int          wq [$];

    ts_memory_responder #(.DEPTH_LOG2(8), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) dut_a (
        .clock(clock), .reset(reset), .data(bus_a), .address(address),
        .mem_read(mem_read), .mem_write(mem_write), .ready(ready_a)
`ifdef TS_MEM_FAULT_EN
        , .fault(fault_a)
`endif
    );

    ts_memory_responder #(.DEPTH_LOG2(8), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut_b (
        .clock(clock), .reset(reset), .data(bus_b), .address(address),
        .mem_read(mem_read), .mem_write(mem_write), .ready(ready_b)
`ifdef TS_MEM_FAULT_EN
        , .fault(fault_b)
`endif
    );

    ts_memory_responder #(.DEPTH_LOG2(8), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) dut_c (
        .clock(clock), .reset(reset), .data(bus_c), .address(address),
        .mem_read(mem_read), .mem_write(mem_write), .ready(ready_c)
`ifdef TS_MEM_FAULT_EN
        , .fault(fault_c)
`endif
    );

    ts_memory_responder #(.DEPTH_LOG2(8), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(1)) dut_d (
        .clock(clock), .reset(reset), .data(bus_d), .address(address),
        .mem_read(mem_read), .mem_write(mem_write), .ready(ready_d)
`ifdef TS_MEM_FAULT_EN
        , .fault(fault_d)
`endif
    );

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return ready_a;
            1:       return ready_b;
            2:       return ready_c;
            default: return ready_d;
        endcase
    endfunction

    function automatic logic bus_z(input int sel);
        case (sel)
            0:       return z_a;
            1:       return z_b;
            2:       return z_c;
            default: return z_d;
        endcase
    endfunction

    function automatic logic [63:0] bus_of(input int sel);
        case (sel)
            0:       return bus_a;
            1:       return bus_b;
            2:       return bus_c;
            default: return bus_d;
        endcase
    endfunction

    function automatic int ws_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    // Ready is seen after WS+1 edges for reads; writes always spend at least one cycle in the wait state.
    function automatic int exp_rlat(input int sel);
        return ws_of(sel) + 1;
    endfunction

    function automatic int exp_wlat(input int sel);
        return ((ws_of(sel) == 0) ? 1 : ws_of(sel)) + 1;
    endfunction

    task automatic do_write(input int sel, input logic [31:0] addr, input logic [63:0] val,
                            input logic both, input string tag);
        int lat;
        lat       = 0;
        address   = addr;
        mem_write = 1'b1;
        mem_read  = both;
        tb_en     = 1'b1;
        tb_val    = val;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            tb_val = ~val;
            if (rdy(sel)) begin
                lat = k;
                break;
            end
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        tb_en     = 1'b0;
        n_cmp++;
        if (lat != exp_wlat(sel)) begin
            n_fail++;
            $display("FAIL %s write_latency got %0d expected %0d", tag, lat, exp_wlat(sel));
        end
        @(negedge clock);
    endtask

    task automatic do_read(input int sel, input logic [31:0] addr, input logic [63:0] exp,
                           input string tag);
        int          lat;
        logic [63:0] got;
        lat      = 0;
        got      = '0;
        address  = addr;
        mem_read = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (rdy(sel)) begin
                lat = k;
                got = bus_of(sel);
                break;
            end
            n_cmp++;
            if (!bus_z(sel)) begin
                n_fail++;
                $display("FAIL %s bus_driven_before_ready cycle %0d got %h expected z", tag, k, bus_of(sel));
            end
        end
        n_cmp++;
        if (lat != exp_rlat(sel)) begin
            n_fail++;
            $display("FAIL %s read_latency got %0d expected %0d", tag, lat, exp_rlat(sel));
        end
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s read_data got %h expected %h", tag, got, exp);
        end
        @(negedge clock);
        n_cmp++;
        if (rdy(sel) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_pulse_width got %b expected 0", tag, rdy(sel));
        end
        mem_read = 1'b0;
        #1;
        n_cmp++;
        if (!bus_z(sel)) begin
            n_fail++;
            $display("FAIL %s bus_release got %h expected z", tag, bus_of(sel));
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        address  = 32'h0;
        mem_read = 1'b1;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (rdy(s) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready dut%0d got %b expected 0", s, rdy(s));
            end
            n_cmp++;
            if (!bus_z(s)) begin
                n_fail++;
                $display("FAIL reset_bus dut%0d got %h expected z", s, bus_of(s));
            end
        end
`ifdef TS_MEM_FAULT_EN
        n_cmp++;
        if ({fault_a, fault_b, fault_c, fault_d} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_fault got %b expected 0000", {fault_a, fault_b, fault_c, fault_d});
        end
`endif
        mem_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        do_write(0, 32'h10, 64'hDEAD_BEEF_0123_4567, 1'b0, "ws1_wr_10");
        do_read(0, 32'h10, 64'hDEAD_BEEF_0123_4567, "ws1_rd_10");
    endtask

    task automatic test_back_to_back();
        do_write(1, 32'h0, 64'h0123_4567_89AB_CDEF, 1'b0, "ws0_wr_0");
        do_write(1, 32'h8, 64'hFEDC_BA98_7654_3210, 1'b0, "ws0_wr_8");
        do_read(1, 32'h0, 64'h0123_4567_89AB_CDEF, "ws0_rd_0");
        do_read(1, 32'h8, 64'hFEDC_BA98_7654_3210, "ws0_rd_8");
    endtask

    task automatic test_miss();
        address  = 32'h0;
        mem_read = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            n_cmp++;
            if (ready_d !== 1'b0 || !z_d) begin
                n_fail++;
                $display("FAIL miss cycle %0d ready got %b expected 0, bus got %h expected z", k, ready_d, bus_d);
            end
        end
        mem_read = 1'b0;
        @(negedge clock);
        do_write(3, 32'h1010, 64'h5A5A_0000_FFFF_1234, 1'b0, "base1000_wr");
        do_read(3, 32'h1010, 64'h5A5A_0000_FFFF_1234, "base1000_rd");
    endtask

    task automatic test_reset_abort();
        do_write(2, 32'h18, 64'hCAFE_F00D_0000_0018, 1'b0, "ws3_prior");
        address   = 32'h18;
        mem_write = 1'b1;
        tb_en     = 1'b1;
        tb_val    = 64'h1;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_cmp++;
            if (ready_c !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_abort_ready cycle %0d got %b expected 0", k, ready_c);
            end
        end
        mem_write = 1'b0;
        tb_en     = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_read(2, 32'h18, 64'hCAFE_F00D_0000_0018, "ws3_after_reset");
        address  = 32'h8;
        mem_read = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (z_b) begin
            n_fail++;
            $display("FAIL ws0_drive_before_reset got z expected %h", 64'hFEDC_BA98_7654_3210);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (!z_b) begin
            n_fail++;
            $display("FAIL reset_releases_bus got %h expected z", bus_b);
        end
        @(negedge clock);
        mem_read = 1'b0;
        reset    = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_misaligned();
        do_write(0, 32'h8, 64'h1111_2222_3333_4444, 1'b0, "dw1_wr");
`ifdef TS_MEM_FAULT_EN
        address  = 32'h0C;
        mem_read = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            n_cmp++;
            if (fault_a !== (k == 1) || ready_a !== 1'b0 || !z_a) begin
                n_fail++;
                $display("FAIL misaligned cycle %0d fault got %b expected %b, ready got %b expected 0, bus z got %b expected 1",
                         k, fault_a, (k == 1), ready_a, z_a);
            end
        end
        mem_read = 1'b0;
        @(negedge clock);
        address   = 32'h20;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (fault_a !== 1'b1 || ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wr_both fault got %b expected 1, ready got %b expected 0", fault_a, ready_a);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clock);
`else
        do_read(0, 32'h0C, 64'h1111_2222_3333_4444, "misaligned_rd");
        do_write(0, 32'h20, 64'h7777_8888_9999_AAAA, 1'b1, "rd_wr_as_write");
        do_read(0, 32'h20, 64'h7777_8888_9999_AAAA, "rd_wr_check");
`endif
    endtask

    task automatic test_random();
        int          idx;
        int          op;
        logic [63:0] val;
        for (int n = 0; n < 60; n++) begin
            op  = $urandom_range(0, 4);
            idx = $urandom_range(0, 255);
            val = {$urandom(), $urandom()};
            if (op <= 1 || wq.size() == 0) begin
                do_write(0, 32'(idx) << 3, val, 1'b0, "rnd_wr");
                if (model[idx] === 64'bx || !(idx inside {wq})) wq.push_back(idx);
                model[idx] = val;
            end else if (op <= 3) begin
                idx = wq[$urandom_range(0, wq.size() - 1)];
                do_read(0, 32'(idx) << 3, model[idx], "rnd_rd");
            end else begin
                idx       = wq[$urandom_range(0, wq.size() - 1)];
                address   = 32'(idx) << 3;
                mem_write = 1'b1;
                tb_en     = 1'b1;
                tb_val    = val;
                @(negedge clock);
                mem_write = 1'b0;
                tb_en     = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    n_cmp++;
                    if (ready_a !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rnd_abort_ready cycle %0d got %b expected 0", k, ready_a);
                    end
                    @(negedge clock);
                end
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        address   = 32'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tb_en     = 1'b0;
        tb_val    = 64'h0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_miss();
        test_reset_abort();
        test_misaligned();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
